// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: access-size
// encodings, FSM state encoding and the request fault check.
package lsu_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  // A request faults on the illegal size code, on a misaligned half/word,
  // or when it addresses bytes beyond the 4 << aw byte data memory.
  function automatic logic is_fault(input logic [1:0]  sz,
                                    input logic [31:0] a,
                                    input int unsigned aw);
    logic misalign;
    logic out_of_range;
    misalign     = ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a[1:0] != 2'b00));
    out_of_range = ((a >> (aw + 2)) != 32'd0);
    return (sz == 2'b11) || misalign || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts and extends the addressed lane of a loaded
// word, and merges right-aligned store data into a word for sub-word stores.
module lsu_lane
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_data,
  input  logic [31:0] mg_word,
  input  logic [31:0] st_data,
  output logic [31:0] mg_data
);

  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] mask;

  assign sh = {off, 3'b000};

  // Load: shift the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    lane = 16'(rd_word >> sh);
    case (size)
      SZ_B:    ld_data = {{24{sext & lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = {{16{sext & lane[15]}}, lane};
      default: ld_data = rd_word;
    endcase
  end

  // Store merge: replace only the addressed byte/half of the old word.
  always_comb begin
    case (size)
      SZ_B:    mask = 32'h0000_00FF << sh;
      SZ_H:    mask = 32'h0000_FFFF << sh;
      default: mask = '1;
    endcase
    mg_data = (mg_word & ~mask) | ((st_data << sh) & mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the CPU pipeline and a word-wide data
// memory. Sub-word stores are done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; faulting requests are rejected here
// LOAD  | memory word addressed, lane extracted into rdata
// RD    | old word captured into the merge register (sub-word store)
// WR    | write enable asserted with word or merged data
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             wr,
  input  logic [1:0]       size,
  input  logic             sext,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             ready,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        fault;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        sext_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] ld_data;
  logic [31:0] mg_data;

  assign accept = req && ready;
  assign fault  = is_fault(size, addr, DM_AW);

  lsu_lane u_lane (
    .size    (size_q),
    .off     (off_q),
    .sext    (sext_q),
    .rd_word (dm_dout),
    .ld_data (ld_data),
    .mg_word (merge_q),
    .st_data (wdata_q),
    .mg_data (mg_data)
  );

  // State register; reset forces IDLE so dm_we drops asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: the direction (wr) is carried in the chosen path.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && !fault) begin
          if (!wr)                state_nx = LOAD;
          else if (size == SZ_W)  state_nx = WR;
          else                    state_nx = RD;
        end
      end
      LOAD:    state_nx = IDLE;
      RD:      state_nx = WR;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state alone; write data only driven during WR.
  always_comb begin
    ready  = (state == IDLE);
    dm_we  = (state == WR);
    dm_din = '0;
    if (state == WR) dm_din = (size_q == SZ_W) ? wdata_q : mg_data;
  end

  // Request capture, merge register and registered done/err/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= SZ_B;
      off_q   <= 2'b00;
      sext_q  <= 1'b0;
      dm_addr <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= (state == LOAD) || (state == WR);
      err  <= accept && fault;
      if (accept) begin
        size_q  <= size;
        off_q   <= addr[1:0];
        sext_q  <= sext;
        dm_addr <= addr[DM_AW+1:2];
        wdata_q <= wdata;
      end
      if (state == RD)   merge_q <= dm_dout;
      if (state == LOAD) rdata   <= ld_data;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: word memory model attached to the DUT, a
// behavioural reference scheduling expected events per cycle, directed
// literal checks and a randomized request stream.
module tb_lsu_ctrl;

  localparam int DM_AW = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic             wr = 1'b0;
  logic [1:0]       size = 2'b00;
  logic             sext = 1'b0;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic             ready;
  logic             done;
  logic [31:0]      rdata;
  logic             err;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_din;
  logic             dm_we;
  logic [31:0]      dm_dout;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  bit          done_at    [int];
  bit          err_at     [int];
  bit          busy_at    [int];
  logic [31:0] rdata_at   [int];
  int          we_addr_at [int];
  logic [31:0] we_data_at [int];
  logic [31:0] hold = '0;

  lsu_ctrl #(.DM_AW(DM_AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .sext    (sext),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_dout (dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_we) mem[dm_addr] <= dm_din;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic bit model_fault(input int unsigned sz, input int unsigned a);
    if (sz == 3) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int unsigned off,
                                             input int unsigned sz, input bit sx);
    longint unsigned v;
    int unsigned     nbits;
    if (sz == 2) return w;
    nbits = 32'd8 << sz;
    v = longint'(w >> (8 * off)) % (64'd1 << nbits);
    if (sx && v >= (64'd1 << (nbits - 1))) v = v + 64'h1_0000_0000 - (64'd1 << nbits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input int unsigned off,
                                              input int unsigned sz, input logic [31:0] d);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    for (int i = 0; i < (1 << sz); i++) b[off + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Drive a request, hold it until accepted, and schedule its expected effects.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d);
    int e;
    int idx;
    int off;
    int guard;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      chk("accept_timeout", {31'd0, ready}, 32'd1);
      req = 1'b0;
      return;
    end
    e   = cyc + 1;
    idx = int'((a >> 2) % 1024);
    off = int'(a % 4);
    if (model_fault(sz, a)) begin
      err_at[e] = 1'b1;
    end else if (!w) begin
      busy_at[e]      = 1'b1;
      done_at[e+1]    = 1'b1;
      rdata_at[e+1]   = model_load(ref_mem[idx], off, sz, sx);
    end else if (sz == 2'b10) begin
      busy_at[e]      = 1'b1;
      we_addr_at[e]   = idx;
      we_data_at[e]   = d;
      ref_mem[idx]    = d;
      done_at[e+1]    = 1'b1;
    end else begin
      busy_at[e]      = 1'b1;
      busy_at[e+1]    = 1'b1;
      we_addr_at[e+1] = idx;
      we_data_at[e+1] = model_merge(ref_mem[idx], off, sz, d);
      ref_mem[idx]    = we_data_at[e+1];
      done_at[e+2]    = 1'b1;
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_ready",   {31'd0, ready}, 32'd1);
    chk("rst_done",    {31'd0, done},  32'd0);
    chk("rst_err",     {31'd0, err},   32'd0);
    chk("rst_rdata",   rdata,          32'd0);
    chk("rst_dm_we",   {31'd0, dm_we}, 32'd0);
    chk("rst_dm_addr", 32'(dm_addr),   32'd0);
    chk("rst_dm_din",  dm_din,         32'd0);
  endtask

  task automatic clear_model();
    done_at.delete();
    err_at.delete();
    busy_at.delete();
    rdata_at.delete();
    we_addr_at.delete();
    we_data_at.delete();
    hold = '0;
  endtask

  // Per-cycle comparison of every DUT output against the scheduled model.
  always @(negedge clk) begin : compare
    bit we_exp;
    if (chk_en) begin
      we_exp = we_addr_at.exists(cyc) != 0;
      chk("done",  {31'd0, done},  {31'd0, done_at.exists(cyc) != 0});
      chk("err",   {31'd0, err},   {31'd0, err_at.exists(cyc) != 0});
      chk("ready", {31'd0, ready}, {31'd0, busy_at.exists(cyc) == 0});
      chk("dm_we", {31'd0, dm_we}, {31'd0, we_exp});
      if (we_exp) begin
        chk("dm_addr", 32'(dm_addr), 32'(we_addr_at[cyc]));
        chk("dm_din",  dm_din,       we_data_at[cyc]);
      end
      if (rdata_at.exists(cyc)) hold = rdata_at[cyc];
      chk("rdata", rdata, hold);
    end
  end

  initial begin
    int t0;
    logic [31:0] saved;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'h8899_AABB;
    ref_mem[16] = 32'h8899_AABB;

    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // lb / lbu at 0x41
    do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lb_done",  {31'd0, done}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lbu_rdata", rdata, 32'h0000_00AA);

    // sh 0x1234 at 0x42 (read-modify-write)
    do_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_1234);
    @(negedge clk);
    chk("sh_we_t1",    {31'd0, dm_we}, 32'd0);
    chk("sh_ready_t1", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("sh_we_t2",  {31'd0, dm_we}, 32'd1);
    chk("sh_din_t2", dm_din, 32'h1234_AABB);
    @(negedge clk);
    chk("sh_done_t3", {31'd0, done},  32'd1);
    chk("sh_we_t3",   {31'd0, dm_we}, 32'd0);

    // sw 0xDEADBEEF at 0x100
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_we_t1",    {31'd0, dm_we}, 32'd1);
    chk("sw_addr_t1",  32'(dm_addr), 32'h040);
    chk("sw_ready_t1", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("sw_done_t2", {31'd0, done}, 32'd1);

    // faulting lw 0x102 and lh 0x001
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    @(negedge clk);
    chk("lw_mis_err",   {31'd0, err},   32'd1);
    chk("lw_mis_we",    {31'd0, dm_we}, 32'd0);
    chk("lw_mis_ready", {31'd0, ready}, 32'd1);
    do_req(1'b0, 2'b01, 1'b1, 32'h001, 32'h0);
    @(negedge clk);
    chk("lh_mis_err",   {31'd0, err},   32'd1);
    chk("lh_mis_ready", {31'd0, ready}, 32'd1);

    // load accepted in the done cycle of a word store
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D);
    t0 = cyc;
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    chk("b2b_gap", 32'(cyc - t0), 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_rdata", rdata, 32'hCAFE_F00D);

    // reset during WR of an sb
    saved = mem[32];
    do_req(1'b1, 2'b00, 1'b0, 32'h81, 32'h0000_0055);
    @(negedge clk);
    @(negedge clk);
    chk("sb_we_before_rst", {31'd0, dm_we}, 32'd1);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", {31'd0, dm_we}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 32'd0);
    end
    check_reset_values();
    chk("rst_mem_kept", mem[32], saved);
    ref_mem[32] = saved;
    clear_model();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // randomized stream
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sz = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
      if ($urandom_range(0, 24) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DM_AW, default 10, meaning the data-memory word-address width (1024 words, 4 KB).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 1 bit: the CPU requests an access.
REQ-005 The block SHALL have port wr, input, 1 bit: 1 means store, 0 means load.
REQ-006 The block SHALL have port size, input, 2 bits: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 The block SHALL have port sext, input, 1 bit: sign-extend a load (lb/lh) when 1, zero-extend (lbu/lhu) when 0.
REQ-008 The block SHALL have port addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port ready, output, 1 bit: the block can accept a request this cycle; the pipeline stalls when ready is 0.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking completion of the accepted access.
REQ-012 The block SHALL have port rdata, output, 32 bits: formatted load result, valid while done is 1 for a load.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected (faulting) request.
REQ-014 The block SHALL have port dm_addr, output, DM_AW bits: word address driven to the data memory.
REQ-015 The block SHALL have port dm_din, output, 32 bits: write data driven to the data memory.
REQ-016 The block SHALL have port dm_we, output, 1 bit: data-memory write enable.
REQ-017 The block SHALL have port dm_dout, input, 32 bits: data-memory read data, combinational from dm_addr with no byte-lane logic.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, LOAD, RD (read for merge), WR.
REQ-019 ready SHALL equal (state==IDLE); a request is accepted when req and ready are both 1 at a rising edge (cycle T), and addr, wr, size, sext and wdata SHALL be latched at that edge.
REQ-020 A request SHALL fault when any of these holds: size==11; size==01 with addr[0]==1; size==10 with addr[1:0]!=0; addr[31:DM_AW+2]!=0.
REQ-021 A faulting request SHALL pulse err at T+1, SHALL NOT pulse done, SHALL NOT assert dm_we, and the FSM SHALL stay in IDLE.
REQ-022 Load path: IDLE->LOAD; in LOAD, dm_addr SHALL equal the latched addr[DM_AW+1:2]; the selected lane SHALL be extracted by addr[1:0] and extended per sext, registered into rdata; done SHALL pulse at T+2; then LOAD->IDLE.
REQ-023 Word store path: IDLE->WR; in WR, dm_we=1 and dm_din=wdata; done SHALL pulse at T+2; then WR->IDLE.
REQ-024 Sub-word store path (read-modify-write): IDLE->RD->WR; RD SHALL capture dm_dout into a merge register; WR SHALL write the merge register with only the addressed byte or half replaced from wdata[7:0] or wdata[15:0]; done SHALL pulse at T+3.
REQ-025 dm_we SHALL be 1 only in state WR and SHALL be decoded from state alone.
REQ-026 done, err and rdata SHALL be registered outputs; rdata SHALL hold its value until the next load completes.
REQ-027 A req arriving while ready is 0 SHALL be ignored, and the requester SHALL hold it until accepted.
REQ-028 Back-to-back requests SHALL be supported: a new request may be accepted in the same cycle that done pulses, since the FSM is in IDLE then.

Reset
REQ-029 While rst_n is 0, outputs SHALL be: state=IDLE, ready=1, done=0, err=0, rdata=0, dm_we=0, dm_addr=0, dm_din=0.
REQ-030 Reset asserted mid-operation (including in WR) SHALL drop dm_we immediately and asynchronously; the in-flight access SHALL be abandoned with no done.

Structure
REQ-031 A shared package SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state encoding.
REQ-032 One sub-module, lsu_lane, SHALL hold the combinational load extract/extend and store merge logic.

Verification
REQ-033 Bench: memory word 0x40=0x8899AABB; lb at 0x41 with sext=1 -> rdata=0xFFFFFFAA at T+2; lbu at the same address -> 0x000000AA.
REQ-034 Bench: sh of 0x1234 at 0x42 onto 0x8899AABB -> exactly one dm_we cycle at T+2 with dm_din=0x1234AABB; done at T+3.
REQ-035 Bench: sw of 0xDEADBEEF at 0x100 -> dm_we at T+1, dm_addr=0x040; done at T+2; ready=0 during T+1.
REQ-036 Bench: lw at 0x102 and lh at 0x001 -> err at T+1 each, no dm_we, ready stays 1.
REQ-037 Bench: rst_n pulled low in WR of an sb -> dm_we=0 immediately, target word unchanged, no done.
REQ-038 Bench: a load accepted in the done cycle of a preceding sw -> the load returns the newly written data.
